// File: rtl/sa_req_sequencer.sv
// Initiator for the sa start/done handshake: FIFO of targets, start sequencing, result capture.
// Optional SA_SEQ_TIMEOUT_EN: bound the wait for sa_done and report a timeout result (res_err=1).
module sa_req_sequencer #(
  parameter int YW      = 10,
  parameter int XW      = 4,
  parameter int DEPTH   = 4,
  parameter int SETUP   = 1,
  parameter int START_W = 1,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tgt_valid,
  output logic          tgt_ready,
  input  logic [YW-1:0] tgt_data,
  output logic [YW-1:0] sa_y_t,
  output logic          sa_start,
  input  logic          sa_done,
  input  logic [XW-1:0] sa_x,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [XW-1:0] res_x,
  output logic [YW-1:0] res_y_t,
  output logic          res_err,
  output logic          busy
);
  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // valid never waits on ready, and offered data stays stable until accepted.

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMAX = (TIMEOUT > SETUP) ? ((TIMEOUT > START_W) ? TIMEOUT : START_W)
                                          : ((SETUP > START_W) ? SETUP : START_W);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_DONE, S_WAIT_LOW, S_PUSH
  } state_t;

  state_t          state, state_nxt;
  logic [YW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            fifo_empty, fifo_full, push, pop;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [YW-1:0]   y_q;
  logic [XW-1:0]   x_cap;
  logic            cap_ok, res_load;
`ifdef SA_SEQ_TIMEOUT_EN
  logic            cap_to, err_cap;
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tgt_ready  = ~fifo_full & ~rst;
  assign push       = tgt_valid & tgt_ready;
  assign sa_y_t     = y_q;
  assign sa_start   = (state == S_START);
  assign busy       = (state != S_IDLE) | ~fifo_empty;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    cap_ok    = 1'b0;
    res_load  = 1'b0;
`ifdef SA_SEQ_TIMEOUT_EN
    cap_to    = 1'b0;
`endif
    unique case (state)
      S_IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_LOAD;
      end
      S_LOAD: if (cnt == CW'(SETUP - 1)) begin
        cnt_nxt   = '0;
        state_nxt = S_START;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
      // Counter is cleared on the way into WAIT_DONE so the timeout starts fresh.
      S_START: if (cnt == CW'(START_W - 1)) begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT_DONE;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
      S_WAIT_DONE: begin
        if (sa_done) begin
          cap_ok    = 1'b1;
          state_nxt = S_WAIT_LOW;
        end
`ifdef SA_SEQ_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          cap_to    = 1'b1;
          state_nxt = S_PUSH;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      S_WAIT_LOW: if (!sa_done) state_nxt = S_PUSH;
      S_PUSH: if (!res_valid || res_ready) begin
        res_load  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tgt_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      y_q       <= '0;
      x_cap     <= '0;
      res_valid <= 1'b0;
      res_x     <= '0;
      res_y_t   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        y_q    <= mem[rd_ptr[AW-1:0]];
      end
      if (cap_ok) x_cap <= sa_x;
`ifdef SA_SEQ_TIMEOUT_EN
      if (cap_to) x_cap <= '0;
`endif
      // A load in the same cycle as an accept keeps res_valid high with fresh data.
      if (res_load) begin
        res_valid <= 1'b1;
        res_x     <= x_cap;
        res_y_t   <= y_q;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef SA_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cap <= 1'b0;
      res_err <= 1'b0;
    end else begin
      if (cap_ok) err_cap <= 1'b0;
      if (cap_to) err_cap <= 1'b1;
      if (res_load) res_err <= err_cap;
    end
  end
`else
  assign res_err = 1'b0;
`endif

endmodule
